// File: rtl/sensor_frame_reader_pkg.sv
// Shared types and constants for the sensor frame reader,
// the sensor register bank and ground-side decoders.
package sensor_frame_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2
  } state_e;

  localparam logic [7:0] SYNC0_DEF  = 8'hA5;
  localparam logic [7:0] SYNC1_DEF  = 8'h5A;

  localparam logic [7:0] ADDR_PRESS = 8'd1;
  localparam logic [7:0] ADDR_TEMP  = 8'd5;
  localparam logic [7:0] ADDR_ACCEL = 8'd8;
  localparam logic [7:0] ADDR_GYRO  = 8'd14;
  localparam logic [7:0] ADDR_MAGM  = 8'd20;
  localparam logic [7:0] ADDR_FIRST = 8'd1;
  localparam logic [7:0] ADDR_LAST  = 8'd25;

  function automatic logic [7:0] chk8_neg(
    input logic [7:0] sum
  );
    return 8'(~sum + 8'd1);
  endfunction

endpackage

// File: rtl/telemetry_chk8.sv
// Running 8-bit sum with clear/add and a
// two's complement output that zeroes the total.
module telemetry_chk8
  import sensor_frame_reader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_add,
  input  logic [7:0] i_d,
  output logic [7:0] o_neg
);

  logic [7:0] r_sum;

  // accumulate; a clear may load the first byte in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum <= 8'd0;
    end else if (i_clr) begin
      r_sum <= i_add ? i_d : 8'd0;
    end else if (i_add) begin
      r_sum <= r_sum + i_d;
    end
  end

  assign o_neg = chk8_neg(r_sum);

endmodule

// File: rtl/sensor_frame_reader.sv
// Fetches a bank snapshot into a local buffer and
// streams it as a framed, checksummed telemetry packet.
module sensor_frame_reader
  import sensor_frame_reader_pkg::*;
#(
  parameter logic [7:0]  FIRST_ADDR = ADDR_FIRST,
  parameter logic [7:0]  LAST_ADDR  = ADDR_LAST,
  parameter logic [7:0]  SYNC0      = SYNC0_DEF,
  parameter logic [7:0]  SYNC1      = SYNC1_DEF,
  parameter int unsigned PERIOD     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] addr,
  input  logic [7:0] data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  localparam int         N     = int'(LAST_ADDR) - int'(FIRST_ADDR) + 1;
  localparam logic [5:0] FEND  = 6'(N);
  localparam logic [5:0] SLAST = 6'(N + 3);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [5:0]  r_fidx;
  logic [5:0]  r_sidx;
  logic [7:0]  r_addr;
  logic [7:0]  r_seq;
  logic        r_pend;
  logic        r_ovr;
  logic [31:0] r_pcnt;
  logic [7:0]  r_buf [N];

  logic       w_wrap;
  logic       w_trig;
  logic       w_hs;
  logic       w_last;
  logic       w_enter;
  logic       w_smp;
  logic       w_pay;
  logic       w_shift;
  logic [7:0] w_seq_nxt;
  logic [7:0] w_chk;

  assign w_wrap    = (PERIOD != 0) && (r_pcnt == 32'(PERIOD - 1));
  assign w_trig    = start | w_wrap;
  assign w_hs      = tx_valid & tx_ready;
  assign w_last    = w_hs && (r_sidx == SLAST);
  assign w_smp     = (r_state == S_FETCH) && (r_fidx < FEND);
  assign w_pay     = (r_sidx >= 6'd3) && (r_sidx < SLAST);
  assign w_shift   = w_smp || (w_hs && w_pay);
  assign w_seq_nxt = w_last ? r_seq + 8'd1 : r_seq;

  assign addr       = r_addr;
  assign busy       = (r_state != S_IDLE);
  assign tx_valid   = (r_state == S_SEND);
  assign frame_done = w_last;
  assign overrun    = r_ovr;

  // free-running auto-trigger counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pcnt <= 32'd0;
    end else if (PERIOD != 0) begin
      r_pcnt <= w_wrap ? 32'd0 : r_pcnt + 32'd1;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // next state; a pending or coincident trigger chains frames
  always_comb begin
    w_state_nxt = r_state;
    w_enter     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_trig) begin
          w_state_nxt = S_FETCH;
          w_enter     = 1'b1;
        end
      end
      S_FETCH: begin
        if (r_fidx == FEND) w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (w_last) begin
          if (r_pend || w_trig) begin
            w_state_nxt = S_FETCH;
            w_enter     = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // fetch index and bank address walk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fidx <= 6'd0;
      r_addr <= 8'd0;
    end else if (w_enter) begin
      r_fidx <= 6'd0;
      r_addr <= FIRST_ADDR;
    end else if (r_state == S_FETCH) begin
      r_fidx <= r_fidx + 6'd1;
      r_addr <= (r_fidx < FEND - 6'd1) ? r_addr + 8'd1 : 8'd0;
    end
  end

  // send index advances only on handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sidx <= 6'd0;
    end else if (r_state == S_FETCH) begin
      r_sidx <= 6'd0;
    end else if (w_hs) begin
      r_sidx <= r_sidx + 6'd1;
    end
  end

  // sequence number, pending request and sticky overrun
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seq  <= 8'd0;
      r_pend <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_seq <= w_seq_nxt;
      if (w_last) begin
        r_pend <= 1'b0;
      end else if (busy && w_trig && !r_pend) begin
        r_pend <= 1'b1;
      end
      if (busy && w_trig && r_pend) r_ovr <= 1'b1;
    end
  end

  // buffer shifts in during fetch and rotates out during send
  always_ff @(posedge clk) begin
    if (w_shift) begin
      for (int i = 0; i < N - 1; i++) r_buf[i] <= r_buf[i + 1];
      r_buf[N - 1] <= (r_state == S_FETCH) ? data : r_buf[0];
    end
  end

  telemetry_chk8 u_chk (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_enter),
    .i_add (w_enter | w_smp),
    .i_d   (w_enter ? w_seq_nxt : data),
    .o_neg (w_chk)
  );

  // packet byte mux
  always_comb begin
    tx_data = 8'd0;
    if (r_state == S_SEND) begin
      unique case (1'b1)
        r_sidx == 6'd0:  tx_data = SYNC0;
        r_sidx == 6'd1:  tx_data = SYNC1;
        r_sidx == 6'd2:  tx_data = r_seq;
        r_sidx == SLAST: tx_data = w_chk;
        default:         tx_data = r_buf[0];
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_frame_reader.sv
// Randomized bench for sensor_frame_reader against a
// packet-level reference model.
module tb_sensor_frame_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       tx_ready = 1'b1;
  logic [7:0] addr, data, tx_data;
  logic       tx_valid, busy, frame_done, overrun;

  logic       rst_p = 1'b0;
  logic       start_p = 1'b0;
  logic       rdy_p = 1'b1;
  logic [7:0] addr_p, data_p, tx_data_p;
  logic       tx_valid_p, busy_p, frame_done_p, overrun_p;

  always #5 clk = ~clk;

  assign data   = addr ^ 8'h3C;
  assign data_p = addr_p ^ 8'h3C;

  sensor_frame_reader u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .addr       (addr),
    .data       (data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  sensor_frame_reader #(.PERIOD(100)) u_per (
    .clk        (clk),
    .rst        (rst_p),
    .start      (start_p),
    .addr       (addr_p),
    .data       (data_p),
    .tx_data    (tx_data_p),
    .tx_valid   (tx_valid_p),
    .tx_ready   (rdy_p),
    .busy       (busy_p),
    .frame_done (frame_done_p),
    .overrun    (overrun_p)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: queue of {last, byte} for every expected packet
  logic [8:0] exp_q[$];
  logic [7:0] m_seq = 8'd0;
  int         m_out = 0;
  logic       m_ovr = 1'b0;
  bit         rdy_rand = 1'b0;
  int         fbytes = 0;
  int         cyc = 0;
  int         rise_q[$];

  function automatic void push_packet(input logic [7:0] s);
    logic [7:0] sum;
    logic [7:0] b;
    sum = s;
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'h5A});
    exp_q.push_back({1'b0, s});
    for (int a = 1; a <= 25; a++) begin
      b = 8'(a) ^ 8'h3C;
      sum = sum + b;
      exp_q.push_back({1'b0, b});
    end
    exp_q.push_back({1'b1, 8'(-sum)});
  endfunction

  function automatic void model_trigger();
    if (m_out < 2) begin
      push_packet(m_seq);
      m_seq = m_seq + 8'd1;
      m_out++;
    end else begin
      m_ovr = 1'b1;
    end
  endfunction

  always @(posedge clk) cyc++;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // stream monitor
  logic [8:0] m_e;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_d = 8'd0;
  always @(negedge clk) begin
    if (rst) begin
      if (stall_prev) begin
        chk("hold_valid", 32'(tx_valid), 32'd1);
        chk("hold_data", 32'(tx_data), 32'(prev_d));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_byte", 32'(tx_data), 32'h100);
        end else begin
          m_e = exp_q.pop_front();
          chk("byte", 32'(tx_data), 32'(m_e[7:0]));
          chk("frame_done", 32'(frame_done), 32'(m_e[8]));
          fbytes++;
          if (m_e[8]) begin
            m_out--;
            fbytes = 0;
          end
        end
      end else begin
        chk("done_quiet", 32'(frame_done), 32'd0);
      end
      stall_prev = tx_valid && !tx_ready;
      prev_d = tx_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  logic busy_p_d = 1'b0;
  always @(negedge clk) begin
    if (rst_p && busy_p && !busy_p_d) rise_q.push_back(cyc);
    busy_p_d = busy_p;
  end

  task automatic pulse_start();
    @(negedge clk);
    model_trigger();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || busy) && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("drain", 32'(exp_q.size() == 0 && !busy), 32'd1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // single frame with address walk
    pulse_start();
    chk("busy_up", 32'(busy), 32'd1);
    for (int k = 0; k < 26; k++) begin
      chk("addr_walk", 32'(addr), (k < 25) ? 32'(k + 1) : 32'd0);
      @(negedge clk);
    end
    wait_drain(200);
    chk("ovr_t1", 32'(overrun), 32'(m_ovr));

    // random backpressure
    rdy_rand = 1'b1;
    repeat (4) begin
      pulse_start();
      wait_drain(600);
    end
    rdy_rand = 1'b0;
    repeat (2) @(negedge clk);

    // pending then overrun
    pulse_start();
    repeat (5) @(negedge clk);
    pulse_start();
    n = 0;
    while (!tx_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("reach_send", 32'(tx_valid), 32'd1);
    repeat (5) @(negedge clk);
    pulse_start();
    wait_drain(400);
    chk("ovr_t3", 32'(overrun), 32'(m_ovr));

    // reset mid-send
    pulse_start();
    n = 0;
    while (fbytes < 10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_b10", 32'(fbytes >= 10), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_valid", 32'(tx_valid), 32'd0);
    chk("mid_addr", 32'(addr), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    exp_q.delete();
    m_seq = 8'd0;
    m_out = 0;
    m_ovr = 1'b0;
    fbytes = 0;
    repeat (2) @(negedge clk);
    chk("mid_ovr", 32'(overrun), 32'd0);
    rst = 1'b1;
    pulse_start();
    wait_drain(200);

    // run through the sequence wrap
    for (int i = 0; i < 256; i++) begin
      pulse_start();
      wait_drain(200);
    end
    chk("seq_wrap", 32'(m_seq), 32'd1);

    // auto-trigger instance
    @(negedge clk);
    rst_p = 1'b1;
    repeat (360) @(negedge clk);
    chk("p_rises", 32'(rise_q.size() >= 3), 32'd1);
    if (rise_q.size() >= 3) begin
      chk("p_int1", 32'(rise_q[1] - rise_q[0]), 32'd100);
      chk("p_int2", 32'(rise_q[2] - rise_q[1]), 32'd100);
    end
    chk("p_ovr0", 32'(overrun_p), 32'd0);
    n = rise_q.size();
    for (int i = 0; i < 120 && rise_q.size() == n; i++) @(negedge clk);
    chk("p_rise4", 32'(rise_q.size() > n), 32'd1);
    rdy_p = 1'b0;
    repeat (150) @(negedge clk);
    chk("p_pend_only", 32'(overrun_p), 32'd0);
    repeat (80) @(negedge clk);
    chk("p_hold", 32'(tx_valid_p), 32'd1);
    chk("p_ovr1", 32'(overrun_p), 32'd1);
    rdy_p = 1'b1;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
